crc8_check: RTL and testbench

CRC8_CHECK -- requirements
Module: crc8_check

---
 rtl/crc8_check_pkg.sv | 13 +
 rtl/crc8_check_bit_engine.sv | 30 +++
 rtl/crc8_check.sv | 122 ++++++++++++
 tb/tb_crc8_check.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc8_check_pkg.sv
// Shared constants and FSM encoding for the CRC-8 frame checker.
package crc8_check_pkg;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/crc8_check_bit_engine.sv
// Serial MSB-first CRC-8 register: one bit folded in per enabled clock.
module crc8_bit_engine
  import crc8_check_pkg::*;
#(
  parameter logic [7:0] POLY = CRC8_POLY
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       shift_en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  logic feedback;

  assign feedback = crc[7] ^ bit_in;

  // Synchronous clear wins over shifting so an abort never folds in a stray bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= CRC8_INIT;
    end else if (clear) begin
      crc <= CRC8_INIT;
    end else if (shift_en) begin
      crc <= {crc[6:0], 1'b0} ^ (feedback ? POLY : 8'h00);
    end
  end

endmodule

// File: rtl/crc8_check.sv
// CRC-8 frame checker: byte handshake, serial CRC over each byte, verdict pulse
// after the byte flagged in_last (the transmitted CRC byte).
module crc8_check
  import crc8_check_pkg::*;
#(
  parameter logic [7:0] POLY = CRC8_POLY
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  input  logic       clr,
  output logic       result_valid,
  output logic       crc_ok,
  output logic [7:0] crc_out,
  output logic [7:0] frame_bytes
);

  state_t      state;
  state_t      next_state;
  logic [7:0]  data_sr;
  logic        last_q;
  logic [2:0]  bit_cnt;
  logic [7:0]  byte_cnt;
  logic [7:0]  crc;
  logic        accept;
  logic        ok_q;
  logic [7:0]  crc_q;
  logic [7:0]  bytes_q;

  assign accept = in_valid & in_ready & ~clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (accept) next_state = ST_SHIFT;
      ST_SHIFT: begin
        if (clr) begin
          next_state = ST_IDLE;
        end else if (bit_cnt == 3'd7) begin
          next_state = last_q ? ST_DONE : ST_IDLE;
        end
      end
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready     = (state == ST_IDLE);
    result_valid = (state == ST_DONE);
    crc_ok       = ok_q;
    crc_out      = crc_q;
    frame_bytes  = bytes_q;
    if (state == ST_DONE) begin
      crc_ok      = (crc == 8'h00);
      crc_out     = crc;
      frame_bytes = byte_cnt;
    end
  end

  // The byte is shifted out of data_sr MSB-first, so bit 7 always feeds the engine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_sr <= 8'h00;
      last_q  <= 1'b0;
      bit_cnt <= 3'd0;
    end else if (accept) begin
      data_sr <= in_data;
      last_q  <= in_last;
      bit_cnt <= 3'd0;
    end else if (state == ST_SHIFT) begin
      data_sr <= {data_sr[6:0], 1'b0};
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= 8'h00;
    end else if (clr || state == ST_DONE) begin
      byte_cnt <= 8'h00;
    end else if (accept && byte_cnt != 8'hFF) begin
      byte_cnt <= byte_cnt + 8'd1;
    end
  end

  // Verdict registers keep the last DONE values visible until the next verdict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ok_q    <= 1'b0;
      crc_q   <= 8'h00;
      bytes_q <= 8'h00;
    end else if (state == ST_DONE) begin
      ok_q    <= (crc == 8'h00);
      crc_q   <= crc;
      bytes_q <= byte_cnt;
    end
  end

  crc8_bit_engine #(
    .POLY(POLY)
  ) u_engine (
    .clk     (clk),
    .rst     (rst),
    .clear   (clr || state == ST_DONE),
    .shift_en(state == ST_SHIFT),
    .bit_in  (data_sr[7]),
    .crc     (crc)
  );

endmodule

// File: tb/tb_crc8_check.sv
// Self-checking bench for crc8_check: byte-wise CRC model feeds a verdict scoreboard.
module tb_crc8_check;

  typedef struct {
    logic       ok;
    logic [7:0] crc;
    logic [7:0] bytes;
  } verdict_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic       clr = 1'b0;
  logic       result_valid;
  logic       crc_ok;
  logic [7:0] crc_out;
  logic [7:0] frame_bytes;

  int checks = 0;
  int errors = 0;
  int pulse_count = 0;
  int busy_min;
  int busy_max;
  logic prev_rv = 1'b0;

  verdict_t   sb[$];
  logic [7:0] frame_q[$];

  crc8_check dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .clr         (clr),
    .result_valid(result_valid),
    .crc_ok      (crc_ok),
    .crc_out     (crc_out),
    .frame_bytes (frame_bytes)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] crc_update(input logic [7:0] c_in, input logic [7:0] b);
    logic [7:0] c;
    c = c_in ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  // Verdict monitor: every pulse must match the oldest expected verdict.
  always @(negedge clk) begin
    if (!rst && result_valid) begin
      pulse_count++;
      checks++;
      if (prev_rv) begin
        errors++;
        $display("[TB] FAIL pulse_width: result_valid high two cycles in a row, required one");
      end
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_pulse: result_valid with crc_out=%02h, required no pulse", crc_out);
      end else begin
        verdict_t exp_v;
        exp_v = sb.pop_front();
        if (crc_ok !== exp_v.ok || crc_out !== exp_v.crc || frame_bytes !== exp_v.bytes) begin
          errors++;
          $display("[TB] FAIL verdict: got ok=%0b crc=%02h bytes=%0d, required ok=%0b crc=%02h bytes=%0d",
                   crc_ok, crc_out, frame_bytes, exp_v.ok, exp_v.crc, exp_v.bytes);
        end
      end
    end
    prev_rv = rst ? 1'b0 : result_valid;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  task automatic send_byte(input logic [7:0] d, input logic last, output int busy);
    int n;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("[TB] FAIL handshake_timeout: in_ready=%0b, required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    busy = 0;
    while (!in_ready && busy < 50) begin
      @(negedge clk);
      busy++;
    end
  endtask

  // Sends frame_q as one frame; the last entry is flagged in_last.
  task automatic send_frame();
    logic [7:0] c;
    int         cnt;
    int         busy;
    verdict_t   v;
    c = 8'h00;
    cnt = 0;
    foreach (frame_q[i]) begin
      c = crc_update(c, frame_q[i]);
      if (cnt < 255) cnt++;
    end
    v.ok    = (c == 8'h00);
    v.crc   = c;
    v.bytes = cnt[7:0];
    sb.push_back(v);
    busy_min = 1000;
    busy_max = 0;
    foreach (frame_q[i]) begin
      send_byte(frame_q[i], (i == frame_q.size() - 1), busy);
      if (i != frame_q.size() - 1) begin
        if (busy < busy_min) busy_min = busy;
        if (busy > busy_max) busy_max = busy;
      end
    end
  endtask

  task automatic check_drained(input string name, input int pulses_before, input int want);
    checks++;
    if (sb.size() != 0 || pulse_count - pulses_before !== want) begin
      errors++;
      $display("[TB] FAIL %s: pending=%0d pulses=%0d, required pending=0 pulses=%0d",
               name, sb.size(), pulse_count - pulses_before, want);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b0 || crc_ok !== 1'b0 || crc_out !== 8'h00 || frame_bytes !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_outputs: rv=%0b ok=%0b crc=%02h bytes=%0d, required all zero",
               result_valid, crc_ok, crc_out, frame_bytes);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready: in_ready=%0b, required 1", in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_pass_frame();
    int p;
    p = pulse_count;
    frame_q = '{8'h01, 8'h07};
    send_frame();
    check_drained("pass_frame", p, 1);
  endtask

  task automatic test_fail_frame();
    int p;
    p = pulse_count;
    frame_q = '{8'h01, 8'h06};
    send_frame();
    check_drained("fail_frame", p, 1);
    repeat (3) @(negedge clk);
    checks++;
    if (crc_ok !== 1'b0 || crc_out !== 8'h07 || frame_bytes !== 8'd2) begin
      errors++;
      $display("[TB] FAIL verdict_hold: ok=%0b crc=%02h bytes=%0d, required ok=0 crc=07 bytes=2",
               crc_ok, crc_out, frame_bytes);
    end
  endtask

  task automatic test_crc_vector();
    int p;
    p = pulse_count;
    frame_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF4};
    send_frame();
    check_drained("vector_123456789", p, 1);
    checks++;
    if (busy_min != 8 || busy_max != 8) begin
      errors++;
      $display("[TB] FAIL busy_cycles: min=%0d max=%0d, required 8", busy_min, busy_max);
    end
  endtask

  task automatic test_single_byte();
    int p;
    p = pulse_count;
    frame_q = '{8'h00};
    send_frame();
    frame_q = '{8'h5A};
    send_frame();
    check_drained("single_byte", p, 2);
  endtask

  task automatic test_clr_abort();
    int p;
    int busy;
    p = pulse_count;
    send_byte(8'h11, 1'b0, busy);
    send_byte(8'h22, 1'b0, busy);
    in_data = 8'h33; in_last = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clr_to_idle: in_ready=%0b, required 1", in_ready);
    end
    frame_q = '{8'h00};
    send_frame();
    check_drained("clr_abort", p, 1);
    // clr together with in_valid in IDLE must not take the byte
    p = pulse_count;
    in_data = 8'hAA; in_last = 1'b0; in_valid = 1'b1; clr = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; clr = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clr_blocks_accept: in_ready=%0b, required 1", in_ready);
    end
    frame_q = '{8'h01, 8'h07};
    send_frame();
    check_drained("clr_with_valid", p, 1);
  endtask

  task automatic test_saturation();
    int p;
    p = pulse_count;
    frame_q.delete();
    for (int i = 0; i < 300; i++) frame_q.push_back(8'h00);
    send_frame();
    check_drained("saturation", p, 1);
  endtask

  task automatic test_rst_mid_shift();
    int p;
    int busy;
    frame_q = '{8'h01, 8'h06};
    send_frame();
    p = pulse_count;
    send_byte(8'h55, 1'b0, busy);
    in_data = 8'h07; in_last = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (result_valid !== 1'b0 || crc_ok !== 1'b0 || crc_out !== 8'h00 || frame_bytes !== 8'h00) begin
      errors++;
      $display("[TB] FAIL rst_outputs: rv=%0b ok=%0b crc=%02h bytes=%0d, required all zero",
               result_valid, crc_ok, crc_out, frame_bytes);
    end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_ready: in_ready=%0b, required 1", in_ready);
    end
    repeat (12) @(negedge clk);
    check_drained("rst_no_verdict", p, 0);
    p = pulse_count;
    frame_q = '{8'h01, 8'h07};
    send_frame();
    check_drained("after_rst_frame", p, 1);
  endtask

  initial begin
    test_reset();
    test_pass_frame();
    test_fail_frame();
    test_crc_vector();
    test_single_byte();
    test_clr_abort();
    test_saturation();
    test_rst_mid_shift();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
